// File: rtl/alu_control_sequencer_if.sv
// Control bus between the hardwired sequencer and the phase-1 datapath:
// IR / memory handshake in, register-transfer strobes out.
interface alu_control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;

    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, RYin;
    logic        RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
    logic        mem_timeout;

    modport master (
        input  ir, mem_ready, stop,
        output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, RYin,
               RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin,
               Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal, mem_timeout
    );

    modport slave (
        output ir, mem_ready, stop,
        input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, RYin,
               RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin,
               Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal, mem_timeout
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired T-state sequencer: fetch T0-T2, execute T3-T6 for ALU, unary and
// mul/div instructions. Strobes are decoded from the state register.
module alu_control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                          clock,
    input  logic                          clear,
    alu_control_sequencer_if.master       bus
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_BIN, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } class_t;

    function automatic class_t classify(input logic [4:0] op);
        case (op) inside
            [OP_ADD:OP_ROL]: return C_BIN;
            OP_MUL, OP_DIV:  return C_MULDIV;
            OP_NEG, OP_NOT:  return C_UNARY;
            OP_NOP:          return C_NOP;
            OP_HALT:         return C_HALT;
            default:         return C_ILLEGAL;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic   [4:0]    op_q, op_d;
    logic   [CW-1:0] wait_q, wait_d;
    logic            timeout_q, timeout_d;

    logic   [4:0]    opcode;
    class_t          cls;
    state_t          retire;
    logic            unused_ir_fields;

    // The IR register is loaded at the end of T2, so the live value is only
    // trusted in T3; later execute states use the opcode captured there.
    assign opcode = (state_q == S_T3) ? bus.ir[31:27] : op_q;
    assign cls    = classify(opcode);
    assign retire = bus.stop ? S_HALT : S_T0;

    // Register fields are consumed by the datapath's select-encode logic.
    assign unused_ir_fields = ^bus.ir[26:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_RST;
            op_q      <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  if (bus.mem_ready) state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                op_d = opcode;
                case (cls)
                    C_BIN, C_MULDIV, C_UNARY: state_d = S_T4;
                    C_HALT:                   state_d = S_HALT;
                    default:                  state_d = retire;
                endcase
            end
            S_T4:   state_d = (cls == C_UNARY) ? retire : S_T5;
            S_T5:   state_d = (cls == C_MULDIV) ? S_T6 : retire;
            S_T6:   state_d = retire;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Wait counter restarts every fetch; the timeout flag is sticky.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (state_q == S_T1 && !bus.mem_ready) begin
            wait_d = (wait_q == CW'(MEM_WAIT_MAX)) ? wait_q : wait_q + 1'b1;
            if (wait_d == CW'(MEM_WAIT_MAX)) timeout_d = 1'b1;
        end
    end

    assign bus.mem_timeout = timeout_q;

    always_comb begin
        bus.PCout   = 1'b0;  bus.MARin   = 1'b0;  bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;  bus.MDRin   = 1'b0;  bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;  bus.RYin    = 1'b0;  bus.RZinLo  = 1'b0;
        bus.RZinHi  = 1'b0;  bus.RZoutLo = 1'b0;  bus.RZoutHi = 1'b0;
        bus.LOin    = 1'b0;  bus.HIin    = 1'b0;  bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;  bus.Grc     = 1'b0;  bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;  bus.alu_op  = 5'd0;  bus.run     = 1'b0;
        bus.illegal = 1'b0;
        case (state_q)
            S_T0: begin
                bus.run = 1'b1; bus.PCout = 1'b1; bus.MARin = 1'b1;
                bus.IncPC = 1'b1; bus.RZinLo = 1'b1;
            end
            S_T1: begin bus.run = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.run = 1'b1; bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                bus.run = 1'b1;
                case (cls)
                    C_BIN, C_MULDIV: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1;
                    end
                    C_UNARY: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RZinLo = 1'b1;
                        bus.alu_op = opcode;
                    end
                    C_ILLEGAL: bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                bus.run = 1'b1;
                case (cls)
                    C_BIN, C_MULDIV: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.RZinLo = 1'b1;
                        bus.RZinHi = (cls == C_MULDIV);
                        bus.alu_op = opcode;
                    end
                    C_UNARY: begin
                        bus.RZoutLo = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                bus.run = 1'b1;
                bus.RZoutLo = 1'b1;
                if (cls == C_MULDIV) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Gra = 1'b1; bus.Rin = 1'b1;
                end
            end
            S_T6: begin bus.run = 1'b1; bus.RZoutHi = 1'b1; bus.HIin = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed corner sequences, a latency table
// and random instruction streams checked against a per-cycle strobe script.
module tb_alu_control_sequencer;
    localparam int MAXW = 15;

    typedef struct packed {
        logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, RYin;
        logic RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin;
        logic Gra, Grb, Grc, Rin, Rout;
        logic [4:0] alu_op;
        logic run, illegal;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        bit          stop;
        int          exp_len;
        ctl_t        exp_last;
        bit          exp_halt;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    alu_control_sequencer_if bus();

    alu_control_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    bit   sticky = 1'b0;
    ctl_t exp_q[$];
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t c;
        c.PCout = bus.PCout;     c.MARin = bus.MARin;     c.IncPC = bus.IncPC;
        c.Read = bus.Read;       c.MDRin = bus.MDRin;     c.MDRout = bus.MDRout;
        c.IRin = bus.IRin;       c.RYin = bus.RYin;       c.RZinLo = bus.RZinLo;
        c.RZinHi = bus.RZinHi;   c.RZoutLo = bus.RZoutLo; c.RZoutHi = bus.RZoutHi;
        c.LOin = bus.LOin;       c.HIin = bus.HIin;       c.Gra = bus.Gra;
        c.Grb = bus.Grb;         c.Grc = bus.Grc;         c.Rin = bus.Rin;
        c.Rout = bus.Rout;       c.alu_op = bus.alu_op;   c.run = bus.run;
        c.illegal = bus.illegal;
        return c;
    endfunction

    // Per-cycle strobe script for one instruction, from T0 to its last state.
    task automatic build(input logic [4:0] op, input int waits);
        ctl_t c;
        exp_q.delete();
        c = '0; c.run = 1; c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.RZinLo = 1;
        exp_q.push_back(c);
        for (int j = 0; j <= waits; j++) begin
            c = '0; c.run = 1; c.Read = 1; c.MDRin = 1; exp_q.push_back(c);
        end
        c = '0; c.run = 1; c.MDRout = 1; c.IRin = 1; exp_q.push_back(c);
        if (op inside {[5'd3:5'd11]}) begin
            c = '0; c.run = 1; c.Grb = 1; c.Rout = 1; c.RYin = 1; exp_q.push_back(c);
            c = '0; c.run = 1; c.Grc = 1; c.Rout = 1; c.RZinLo = 1; c.alu_op = op; exp_q.push_back(c);
            c = '0; c.run = 1; c.RZoutLo = 1; c.Gra = 1; c.Rin = 1; exp_q.push_back(c);
        end else if (op inside {5'd15, 5'd16}) begin
            c = '0; c.run = 1; c.Grb = 1; c.Rout = 1; c.RYin = 1; exp_q.push_back(c);
            c = '0; c.run = 1; c.Grc = 1; c.Rout = 1; c.RZinLo = 1; c.RZinHi = 1; c.alu_op = op;
            exp_q.push_back(c);
            c = '0; c.run = 1; c.RZoutLo = 1; c.LOin = 1; exp_q.push_back(c);
            c = '0; c.run = 1; c.RZoutHi = 1; c.HIin = 1; exp_q.push_back(c);
        end else if (op inside {5'd17, 5'd18}) begin
            c = '0; c.run = 1; c.Grb = 1; c.Rout = 1; c.RZinLo = 1; c.alu_op = op; exp_q.push_back(c);
            c = '0; c.run = 1; c.RZoutLo = 1; c.Gra = 1; c.Rin = 1; exp_q.push_back(c);
        end else begin
            c = '0; c.run = 1; c.illegal = !(op inside {5'd26, 5'd27}); exp_q.push_back(c);
        end
    endtask

    // Timeout is visible once MAXW wait cycles have elapsed in one fetch.
    function automatic bit exp_tmo(input int k, input int waits);
        if (k == 0) return sticky;
        if (k <= waits + 1) return sticky || (k - 1 >= MAXW);
        return sticky || (waits >= MAXW);
    endfunction

    // Next rising edge must enter T0. ncyc > 0 stops early (for reset tests).
    task automatic run_instr(input logic [31:0] ir_v, input int waits, input bit stop_v,
                             input string name, input int ncyc, output bit halted);
        int n;
        build(ir_v[31:27], waits);
        n = (ncyc > 0) ? ncyc : exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            bus.ir        = ir_v;
            bus.mem_ready = (k >= waits + 1);
            bus.stop      = stop_v && (k >= waits + 3);
            #1;
            check($sformatf("%s_c%0d", name, k), 32'({sample(), bus.mem_timeout}),
                  32'({exp_q[k], exp_tmo(k, waits)}));
        end
        halted = 1'b0;
        if (n == exp_q.size()) begin
            if (waits >= MAXW) sticky = 1'b1;
            halted = stop_v || (ir_v[31:27] == 5'd27);
        end
    endtask

    task automatic check_halted(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.ir = $urandom; bus.mem_ready = 1'($urandom); bus.stop = 1'($urandom);
            #1;
            check($sformatf("%s_h%0d", name, i), 32'({sample(), bus.mem_timeout}),
                  32'({26'h0, sticky}));
        end
    endtask

    task automatic assert_clear(input string name);
        clear = 1'b0;
        #1;
        check(name, 32'({sample(), bus.mem_timeout}), 32'h0);
        sticky = 1'b0;
    endtask

    task automatic release_clear();
        repeat (2) @(posedge clock);
        #1;
        bus.stop = 1'b0;
        clear = 1'b1;
    endtask

    task automatic do_reset(input string name);
        @(posedge clock); #1;
        assert_clear(name);
        release_clear();
    endtask

    // Independent of the script: measure DUT latency and the last execute state.
    task automatic measure(input vec_t v, input int idx);
        ctl_t cur, prev;
        int   len;
        prev = '0; cur = '0; len = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            bus.ir        = v.ir;
            bus.mem_ready = (k >= v.waits + 1);
            bus.stop      = v.stop && (k >= v.waits + 3);
            #1;
            cur = sample();
            if (k > 0 && (cur.PCout || !cur.run)) break;
            prev = cur;
            len++;
        end
        check($sformatf("tbl%0d_len", idx), 32'(len), 32'(v.exp_len));
        check($sformatf("tbl%0d_last", idx), 32'(prev), 32'(v.exp_last));
        check($sformatf("tbl%0d_halt", idx), 32'(!cur.run), 32'(v.exp_halt));
    endtask

    initial begin
        ctl_t wb, hi, nopv, illv;
        bit   h;
        logic [4:0] op;

        bus.ir = '0; bus.mem_ready = 1'b0; bus.stop = 1'b0;

        wb = '0;   wb.run = 1; wb.RZoutLo = 1; wb.Gra = 1; wb.Rin = 1;
        hi = '0;   hi.run = 1; hi.RZoutHi = 1; hi.HIin = 1;
        nopv = '0; nopv.run = 1;
        illv = nopv; illv.illegal = 1;
        tbl[0] = '{32'h2A1B8000, 0, 1'b0, 6, wb,   1'b0};
        tbl[1] = '{32'h78130000, 0, 1'b0, 7, hi,   1'b0};
        tbl[2] = '{32'h88000000, 0, 1'b0, 5, wb,   1'b0};
        tbl[3] = '{32'hD0000000, 0, 1'b1, 4, nopv, 1'b1};
        tbl[4] = '{32'hF8000000, 0, 1'b0, 4, illv, 1'b0};
        tbl[5] = '{32'h18000000, 3, 1'b0, 9, wb,   1'b0};
        tbl[6] = '{32'h20000000, 0, 1'b1, 6, wb,   1'b1};
        tbl[7] = '{32'h80000000, 1, 1'b0, 8, hi,   1'b0};
        tbl[8] = '{32'h90000000, 0, 1'b1, 5, wb,   1'b1};

        #2;
        assert_clear("reset_init");
        release_clear();

        // Clear lands in T4 of an add: outputs drop at once, restart at T0.
        run_instr(32'h18000000, 0, 1'b0, "add_pre", 5, h);
        assert_clear("reset_mid_t4");
        release_clear();

        run_instr(32'h2A1B8000, 0, 1'b0, "and", 0, h);
        run_instr(32'h78130000, 0, 1'b0, "mul", 0, h);
        run_instr(32'h18000000, 3, 1'b0, "wait3", 0, h);
        run_instr(32'h18000000, 14, 1'b0, "wait14", 0, h);
        run_instr(32'h18000000, 16, 1'b0, "wait16", 0, h);
        run_instr(32'hD0000000, 0, 1'b0, "nop_sticky", 0, h);
        run_instr(32'h20000000, 0, 1'b1, "sub_stop", 0, h);
        check_halted(3, "stop");
        do_reset("reset_tmo");

        run_instr(32'hF8000000, 0, 1'b0, "illegal", 0, h);
        run_instr(32'hD8000000, 0, 1'b0, "halt", 0, h);
        check_halted(20, "halt");
        do_reset("reset_halt");

        for (int i = 0; i < 9; i++) begin
            measure(tbl[i], i);
            do_reset($sformatf("reset_tbl%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 31));
            run_instr({op, 27'($urandom)}, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                      $sformatf("rnd%0d", i), 0, h);
            if (h) begin
                check_halted(2, $sformatf("rnd%0d", i));
                do_reset($sformatf("reset_rnd%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
